// File: rtl/tqvp_uart_pkg.sv
// tqvp_uart_pkg: constants shared by the tinyQV UART receiver and its receive FIFO
package tqvp_uart_pkg;
  localparam int UART_PAYLOAD_BITS = 8;
  localparam int UART_RX_FIFO_DEPTH_LOG2 = 2;
  localparam int UART_HS_VALID_W = 1;
  localparam int UART_HS_READ_W = 1;
  function automatic int fifo_depth(input int depth_log2);
    return 1 << depth_log2;
  endfunction
endpackage

// File: rtl/tqvp_uart_rx_fifo_if.sv
// tqvp_uart_rx_fifo_if: receiver handshake plus register-side pop/status bundle of the RX FIFO
interface tqvp_uart_rx_fifo_if import tqvp_uart_pkg::*; #(
  parameter int PAYLOAD_BITS = UART_PAYLOAD_BITS,
  parameter int DEPTH_LOG2 = UART_RX_FIFO_DEPTH_LOG2
);
  logic [UART_HS_VALID_W-1:0] uart_rx_valid;
  logic [PAYLOAD_BITS-1:0] uart_rx_data;
  logic [UART_HS_READ_W-1:0] uart_rx_read;
  logic rd_en;
  logic rd_valid;
  logic [PAYLOAD_BITS-1:0] rd_data;
  logic [DEPTH_LOG2:0] level;
  logic almost_full;
  logic overrun;
  logic overrun_clear;
  modport master (
    output uart_rx_valid, uart_rx_data, rd_en, overrun_clear,
    input uart_rx_read, rd_valid, rd_data, level, almost_full, overrun
  );
  modport slave (
    input uart_rx_valid, uart_rx_data, rd_en, overrun_clear,
    output uart_rx_read, rd_valid, rd_data, level, almost_full, overrun
  );
endinterface

// File: rtl/tqvp_uart_fifo_mem.sv
// tqvp_uart_fifo_mem: register array, one synchronous write port, one asynchronous read port
module tqvp_uart_fifo_mem #(
  parameter int W = 8,
  parameter int AW = 2
)(
  input logic clk,
  input logic we,
  input logic [AW-1:0] waddr,
  input logic [W-1:0] wdata,
  input logic [AW-1:0] raddr,
  output logic [W-1:0] rdata
);
  logic [W-1:0] mem [1<<AW];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/tqvp_uart_rx_fifo.sv
// tqvp_uart_rx_fifo: FWFT receive FIFO with almost-full for RTS; TQVP_UART_RX_FIFO_OVERRUN_EN adds drop-on-full overrun
module tqvp_uart_rx_fifo import tqvp_uart_pkg::*; #(
  parameter int PAYLOAD_BITS = UART_PAYLOAD_BITS,
  parameter int DEPTH_LOG2 = UART_RX_FIFO_DEPTH_LOG2,
  parameter int AFULL_LEVEL = fifo_depth(DEPTH_LOG2) - 1
)(
  input logic clk,
  input logic reset,
  tqvp_uart_rx_fifo_if.slave bus
);
  localparam int DEPTH = fifo_depth(DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0] FULL = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] AFULL = AFULL_LEVEL[DEPTH_LOG2:0];
`ifdef TQVP_UART_RX_FIFO_OVERRUN_EN
  localparam bit OVR_MODE = 1'b1;
`else
  localparam bit OVR_MODE = 1'b0;
`endif
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0] count;
  logic [PAYLOAD_BITS-1:0] head;
  logic full, pop, push, full_drop;
  assign full = count == FULL;
  assign pop = bus.rd_en && bus.rd_valid;
  assign full_drop = full && !pop;
  assign bus.uart_rx_read = !reset && bus.uart_rx_valid && (!full || pop || OVR_MODE);
  assign push = bus.uart_rx_read && !full_drop;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= push && !pop ? count + 1'b1 : pop && !push ? count - 1'b1 : count;
    end
  tqvp_uart_fifo_mem #(.W(PAYLOAD_BITS), .AW(DEPTH_LOG2)) u_mem (
    .clk(clk),
    .we(push),
    .waddr(wr_ptr),
    .wdata(bus.uart_rx_data),
    .raddr(rd_ptr),
    .rdata(head)
  );
  assign bus.rd_valid = count != '0;
  assign bus.rd_data = bus.rd_valid ? head : '0;
  assign bus.level = count;
  assign bus.almost_full = count >= AFULL;
`ifdef TQVP_UART_RX_FIFO_OVERRUN_EN
  logic overrun_q;
  // a dropped byte outranks a clear landing in the same cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) overrun_q <= 1'b0;
    else if (bus.uart_rx_read && full_drop) overrun_q <= 1'b1;
    else if (bus.overrun_clear) overrun_q <= 1'b0;
  assign bus.overrun = overrun_q;
`else
  assign bus.overrun = 1'b0;
`endif
endmodule

// File: tb/tb_tqvp_uart_rx_fifo.sv
// tb_tqvp_uart_rx_fifo: randomized and directed checks of the RX FIFO against a queue model
module tb_tqvp_uart_rx_fifo;
  localparam int DEPTH = 4;
  localparam int AFULL = 3;
`ifdef TQVP_UART_RX_FIFO_OVERRUN_EN
  localparam bit OVR = 1'b1;
`else
  localparam bit OVR = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  logic [7:0] q[$];
  bit ovr_m = 1'b0;
  bit last_ack = 1'b0;
  tqvp_uart_rx_fifo_if #(.PAYLOAD_BITS(8), .DEPTH_LOG2(2)) bus();
  tqvp_uart_rx_fifo #(.PAYLOAD_BITS(8), .DEPTH_LOG2(2), .AFULL_LEVEL(AFULL)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    bit pop, full, ack;
    #1;
    pop = bus.rd_en && q.size() != 0;
    full = q.size() == DEPTH;
    ack = bus.uart_rx_valid && (!full || pop || OVR);
    check("uart_rx_read", bus.uart_rx_read, ack);
    check("rd_valid", bus.rd_valid, q.size() != 0);
    check("rd_data", bus.rd_data, q.size() != 0 ? q[0] : 8'h00);
    check("level", bus.level, q.size());
    check("almost_full", bus.almost_full, q.size() >= AFULL);
    check("overrun", bus.overrun, ovr_m);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (ack && !(full && !pop)) q.push_back(bus.uart_rx_data);
    if (OVR && bus.uart_rx_valid && full && !pop) ovr_m = 1'b1;
    else if (OVR && bus.overrun_clear) ovr_m = 1'b0;
    last_ack = ack;
    #1;
  endtask
  task automatic push_byte(input logic [7:0] b);
    bus.uart_rx_valid = 1'b1;
    bus.uart_rx_data = b;
    bus.rd_en = 1'b0;
    step();
    bus.uart_rx_valid = 1'b0;
  endtask
  task automatic pop_one();
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
  endtask
  task automatic drain();
    bus.uart_rx_valid = 1'b0;
    bus.overrun_clear = 1'b0;
    while (q.size() != 0) pop_one();
  endtask
  initial begin
    bus.uart_rx_valid = 1'b1;
    bus.uart_rx_data = 8'h99;
    bus.rd_en = 1'b0;
    bus.overrun_clear = 1'b0;
    #2;
    check("rst_ack", bus.uart_rx_read, 1'b0);
    check("rst_rd_valid", bus.rd_valid, 1'b0);
    check("rst_rd_data", bus.rd_data, 8'h00);
    check("rst_level", bus.level, 3'd0);
    check("rst_afull", bus.almost_full, 1'b0);
    check("rst_overrun", bus.overrun, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    bus.uart_rx_valid = 1'b0;
    push_byte(8'hA5);
    check("a5_data", bus.rd_data, 8'hA5);
    step();
    pop_one();
    check("a5_popped", bus.rd_data, 8'h00);
    for (int r = 0; r < 2; r++) begin
      for (int i = 1; i <= 4; i++) push_byte(8'(16 * r + i));
      check("fill_afull", bus.almost_full, 1'b1);
      drain();
    end
    for (int i = 1; i <= 4; i++) push_byte(8'(i));
    bus.uart_rx_valid = 1'b1;
    bus.uart_rx_data = 8'h55;
    bus.rd_en = 1'b1;
    step();
    bus.uart_rx_valid = 1'b0;
    bus.rd_en = 1'b0;
    check("full_pp_level", bus.level, 3'd4);
    check("full_pp_head", bus.rd_data, 8'h02);
    drain();
    for (int i = 1; i <= 4; i++) push_byte(8'(8'h60 + i));
    bus.uart_rx_valid = 1'b1;
    bus.uart_rx_data = 8'h66;
    repeat (10) step();
    bus.rd_en = 1'b1;
    step();
    drain();
    for (int i = 1; i <= 4; i++) push_byte(8'(8'h70 + i));
    push_byte(8'h77);
    check("ovr_set", bus.overrun, OVR);
    check("ovr_head", bus.rd_data, 8'h71);
    bus.uart_rx_valid = 1'b1;
    bus.uart_rx_data = 8'h78;
    bus.overrun_clear = 1'b1;
    step();
    check("ovr_set_wins", bus.overrun, OVR);
    bus.uart_rx_valid = 1'b0;
    step();
    check("ovr_cleared", bus.overrun, 1'b0);
    drain();
    for (int i = 0; i < 2000; i++) begin
      if (!bus.uart_rx_valid || last_ack) begin
        bus.uart_rx_valid = $urandom_range(0, 2) != 0;
        bus.uart_rx_data = 8'($urandom);
      end
      bus.rd_en = ((i / 100) % 2) != 0 ? $urandom_range(0, 3) == 0 : $urandom_range(0, 3) != 0;
      bus.overrun_clear = $urandom_range(0, 7) == 0;
      step();
    end
    drain();
    for (int i = 1; i <= 3; i++) push_byte(8'(8'h30 + i));
    @(negedge clk);
    reset = 1'b1;
    bus.uart_rx_valid = 1'b1;
    #1;
    check("arst_rd_valid", bus.rd_valid, 1'b0);
    check("arst_level", bus.level, 3'd0);
    check("arst_rd_data", bus.rd_data, 8'h00);
    check("arst_overrun", bus.overrun, 1'b0);
    check("arst_ack", bus.uart_rx_read, 1'b0);
    q.delete();
    ovr_m = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    push_byte(8'h3C);
    check("post_rst_data", bus.rd_data, 8'h3C);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tqvp_uart_rx_fifo.md
# tqvp_uart_rx_fifo

Receive-side buffer sitting directly downstream of the UART receiver in the tinyQV UART peripheral. Accepts each completed byte from the receiver's valid/read handshake, stores it in a small first-word-fall-through FIFO, and presents it to the peripheral register interface. Also produces an almost-full indication for the receiver's RTS flow control and, optionally, a sticky overrun flag.

## Interface
Parameters:
- PAYLOAD_BITS, 8, data bits per entry; matches the receiver payload width.
- DEPTH_LOG2, 2, log2 of FIFO depth; DEPTH = 2**DEPTH_LOG2; legal range 1..4.
- AFULL_LEVEL, DEPTH-1, occupancy at or above which `almost_full` asserts; legal range 1..DEPTH.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- uart_rx_valid  in  1  receiver holds a completed byte.
- uart_rx_data  in  PAYLOAD_BITS  receiver byte; stable while `uart_rx_valid` is high.
- uart_rx_read  out  1  combinational acknowledge to the receiver; the byte is taken this cycle.
- rd_en  in  1  pop request from the register interface.
- rd_valid  out  1  FIFO non-empty.
- rd_data  out  PAYLOAD_BITS  head entry; first-word-fall-through.
- level  out  DEPTH_LOG2+1  current occupancy, 0..DEPTH.
- almost_full  out  1  `level >= AFULL_LEVEL`.
- overrun  out  1  sticky byte-dropped flag; tied 0 without the macro.
- overrun_clear  in  1  clears `overrun`.

## Operation
- Storage: DEPTH x PAYLOAD_BITS array; write pointer, read pointer (DEPTH_LOG2 bits, natural wrap), occupancy count (DEPTH_LOG2+1 bits).
- Push: `push = uart_rx_valid && uart_rx_read && !full_drop`. Data is written at wr_ptr, wr_ptr increments and count increments.
- `uart_rx_read = !reset && uart_rx_valid && (count < DEPTH || pop || overrun mode)`. The receiver leaves READY on the next edge, so each byte is acknowledged exactly once.
- Pop: `pop = rd_en && rd_valid`. rd_ptr increments and count decrements. `rd_en` while empty is ignored, with no pointer movement.
- Simultaneous push and pop at any level, including full: both occur and count is unchanged. At full, the pop frees the slot being written.
- `rd_valid = (count != 0)`. `rd_data = mem[rd_ptr]` when rd_valid is high, otherwise all zeros.
- `almost_full` is derived from the registered count. The register block drives receiver RTS from it.
- Overrun, macro enabled: push attempted when count == DEPTH and no pop. The byte is acknowledged but dropped, and `overrun` sets. When set and clear occur in the same cycle, set wins.

## Timing
- Reset (async assert, synchronous release): pointers 0, count 0, overrun 0. Outputs: rd_valid 0, rd_data 0, level 0, almost_full 0 (AFULL_LEVEL >= 1), uart_rx_read 0. Memory contents are not reset.
- Push latency: byte acknowledged in cycle N appears on rd_data/rd_valid in cycle N+1. level updates in N+1.
- Pop: rd_data shows the next entry in the cycle after the pop edge.
- Reset asserted mid-handshake: acknowledge forced 0 immediately. The receiver's pending byte is kept by the receiver.

## Configuration
- `TQVP_UART_RX_FIFO_OVERRUN_EN` defined: when full, incoming bytes are acknowledged and discarded. This keeps the receiver draining. `overrun` is sticky until `overrun_clear`.
- Not defined: when full and not popping, `uart_rx_read` stays 0 and the receiver holds its byte in READY (back-pressure). `overrun` is constant 0, `overrun_clear` is ignored, and the overrun logic is absent.

## Structure
- Shared package `tqvp_uart_pkg`: default PAYLOAD_BITS, default depth constant, and the receiver/FIFO handshake width constants used by both UART stages.
- One sub-module, `tqvp_uart_fifo_mem`: a register array with a single write port and an asynchronous read port. Pointer, count and flag logic stay in this block.

## Test plan
- Single byte: valid=1, data=0xA5 for one cycle at count 0 -> uart_rx_read=1 that cycle; next cycle rd_valid=1, rd_data=0xA5, level=1; rd_en one cycle -> level=0, rd_data=0x00.
- Fill at DEPTH=4, AFULL_LEVEL=3: push 0x01..0x04 -> almost_full rises when level=3; pops return 0x01,0x02,0x03,0x04 in order, exercising pointer wrap on a second fill.
- Full plus simultaneous push/pop: at level 4, valid=1 (0x55) with rd_en=1 -> acknowledged, level stays 4, rd_data advances, 0x55 is popped last.
- Full without macro: level 4, valid=1, no rd_en for 10 cycles -> uart_rx_read=0 throughout; after one pop, acknowledged in that same cycle.
- Full with macro: level 4, push 0x77 -> uart_rx_read=1, overrun=1, contents unchanged; overrun_clear and a new overrun event in the same cycle -> overrun stays 1.
- Async reset at level 3 mid-cycle -> rd_valid, level and overrun 0 immediately; a subsequent push of 0x3C reads back 0x3C.
